// File: rtl/fp_mul_pkg.sv
// Shared types and widths for the FP multiplier arbiter.
// Holds the sequencer state encoding and datapath/counter widths.
package fp_mul_pkg;

  localparam int FP_W  = 32;
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_HOLD
  } state_e;

endpackage

// File: rtl/floating_point_spmul.sv
// Combinational single-precision multiplier, round-to-nearest-even.
// Subnormal inputs/outputs flush to zero; out-of-range results raise u_flow/o_flow.
module floating_point_spmul (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y,
  output logic        u_flow,
  output logic        o_flow
);

  logic        s;
  logic [7:0]  ea;
  logic [7:0]  eb;
  logic [47:0] prod;
  logic [46:0] frac_n;
  logic        rnd;
  logic [23:0] mant_r;
  logic [9:0]  es;

  assign s  = a[31] ^ b[31];
  assign ea = a[30:23];
  assign eb = b[30:23];

  always_comb begin
    prod   = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    frac_n = prod[47] ? prod[46:0] : {prod[45:0], 1'b0};
    rnd    = frac_n[23] & ((|frac_n[22:0]) | frac_n[24]);
    mant_r = {1'b0, frac_n[46:24]} + {23'b0, rnd};
    // es carries the +127 bias twice; valid exponents span 128..381
    es     = {2'b0, ea} + {2'b0, eb} + {9'b0, prod[47]}
           + {9'b0, mant_r[23]};
    y      = '0;
    u_flow = 1'b0;
    o_flow = 1'b0;
    if (ea == 8'hFF || eb == 8'hFF) begin
      y = {s, 8'hFF, 23'b0};
    end else if (ea == 8'h00 || eb == 8'h00) begin
      y = {s, 31'b0};
    end else if (es >= 10'd382) begin
      y      = {s, 8'hFF, 23'b0};
      o_flow = 1'b1;
    end else if (es <= 10'd127) begin
      y      = {s, 31'b0};
      u_flow = 1'b1;
    end else begin
      y = {s, 8'(es - 10'd127), mant_r[22:0]};
    end
  end

endmodule

// File: rtl/rr_pick.sv
// Round-robin picker: first set bit of req searching upward from last+1.
// Combinational; gnt is one-hot (or zero when req is empty).
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx
);

  logic found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!found && req[(int'(last) + k) % N]) begin
        found = 1'b1;
        gnt[(int'(last) + k) % N] = 1'b1;
        idx = W'((int'(last) + k) % N);
      end
    end
  end

endmodule

// File: rtl/fp_mul_arbiter.sv
// Round-robin sequencer sharing one FP multiplier among NUM_REQ requesters.
// Optional flag counters (ovf_cnt/udf_cnt) enabled by FPMUL_ARB_STATS_EN.
module fp_mul_arbiter
  import fp_mul_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*FP_W-1:0] req_a,
  input  logic [NUM_REQ*FP_W-1:0] req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [FP_W-1:0]         rsp_y,
  output logic                    rsp_uflow,
  output logic                    rsp_oflow
`ifdef FPMUL_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]        ovf_cnt,
  output logic [CNT_W-1:0]        udf_cnt
`endif
);

  state_e state_q, state_d;

  logic [FP_W-1:0] op_a_q, op_a_d;
  logic [FP_W-1:0] op_b_q, op_b_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [ID_W-1:0] last_q, last_d;
  logic [ID_W-1:0] rid_q, rid_d;
  logic [FP_W-1:0] y_q, y_d;
  logic            uf_q, uf_d;
  logic            of_q, of_d;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [ID_W-1:0]    pick_idx;
  logic               accept;
  logic               calc;
  logic [FP_W-1:0]    mul_y;
  logic               mul_u;
  logic               mul_o;

  rr_pick #(
    .N (NUM_REQ),
    .W (ID_W)
  ) u_pick (
    .req  (req_valid),
    .last (last_q),
    .gnt  (pick_gnt),
    .idx  (pick_idx)
  );

  floating_point_spmul u_mul (
    .a      (op_a_q),
    .b      (op_b_q),
    .y      (mul_y),
    .u_flow (mul_u),
    .o_flow (mul_o)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (|req_valid) state_d = ST_CALC;
      ST_CALC: state_d = ST_HOLD;
      ST_HOLD: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (state_q == ST_IDLE && !rst) req_ready = pick_gnt;
    rsp_valid = (state_q == ST_HOLD);
  end

  assign accept = (state_q == ST_IDLE) && (|req_valid);
  assign calc   = (state_q == ST_CALC);

  always_comb begin
    op_a_d = op_a_q;
    op_b_d = op_b_q;
    id_d   = id_q;
    last_d = last_q;
    rid_d  = rid_q;
    y_d    = y_q;
    uf_d   = uf_q;
    of_d   = of_q;
    if (accept) begin
      op_a_d = req_a[FP_W*int'(pick_idx) +: FP_W];
      op_b_d = req_b[FP_W*int'(pick_idx) +: FP_W];
      id_d   = pick_idx;
      last_d = pick_idx;
    end
    if (calc) begin
      y_d   = mul_y;
      uf_d  = mul_u;
      of_d  = mul_o;
      rid_d = id_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_a_q <= '0;
      op_b_q <= '0;
      id_q   <= '0;
      last_q <= ID_W'(NUM_REQ - 1);
      rid_q  <= '0;
      y_q    <= '0;
      uf_q   <= 1'b0;
      of_q   <= 1'b0;
    end else begin
      op_a_q <= op_a_d;
      op_b_q <= op_b_d;
      id_q   <= id_d;
      last_q <= last_d;
      rid_q  <= rid_d;
      y_q    <= y_d;
      uf_q   <= uf_d;
      of_q   <= of_d;
    end
  end

  assign rsp_id    = rid_q;
  assign rsp_y     = y_q;
  assign rsp_uflow = uf_q;
  assign rsp_oflow = of_q;

`ifdef FPMUL_ARB_STATS_EN
  logic [CNT_W-1:0] ovf_q, ovf_d;
  logic [CNT_W-1:0] udf_q, udf_d;

  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (calc && mul_o && ovf_q != '1) ovf_d = ovf_q + 1'b1;
    if (calc && mul_u && udf_q != '1) udf_d = udf_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= '0;
      udf_q <= '0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign ovf_cnt = ovf_q;
  assign udf_cnt = udf_q;
`endif

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Directed bench for fp_mul_arbiter: vector table plus corner sequences.
module tb_fp_mul_arbiter;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [N*32-1:0] req_a;
  logic [N*32-1:0] req_b;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [1:0]    rsp_id;
  logic [31:0]   rsp_y;
  logic          rsp_uflow;
  logic          rsp_oflow;
`ifdef FPMUL_ARB_STATS_EN
  logic [15:0]   ovf_cnt;
  logic [15:0]   udf_cnt;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fp_mul_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_y     (rsp_y),
    .rsp_uflow (rsp_uflow),
    .rsp_oflow (rsp_oflow)
`ifdef FPMUL_ARB_STATS_EN
    ,
    .ovf_cnt   (ovf_cnt),
    .udf_cnt   (udf_cnt)
`endif
  );

  typedef struct {
    int          idx;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
    logic        uf;
    logic        of;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [31:0] a,
                         input logic [31:0] b);
    req_valid[i] = 1'b1;
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  task automatic run_vec(input vec_t v);
    logic [31:0] rdy_exp;
    rdy_exp = 32'(1) << v.idx;
    rsp_ready = 1'b0;
    set_req(v.idx, v.a, v.b);
    #1;
    chk("vec_req_ready", 32'(req_ready), rdy_exp);
    tick();
    req_valid = '0;
    chk("vec_calc_no_valid", 32'(rsp_valid), 32'd0);
    chk("vec_calc_ready0", 32'(req_ready), 32'd0);
    tick();
    chk("vec_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("vec_rsp_y", rsp_y, v.y);
    chk("vec_rsp_id", 32'(rsp_id), 32'(v.idx));
    chk("vec_uflow", 32'(rsp_uflow), 32'(v.uf));
    chk("vec_oflow", 32'(rsp_oflow), 32'(v.of));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("vec_back_idle", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] y_hold;
    logic [31:0] ry [4];
    vecs[0] = '{2, 32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0};
    vecs[1] = '{1, 32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b0, 1'b1};
    vecs[2] = '{3, 32'h00800000, 32'h00800000, 32'h00000000, 1'b1, 1'b0};
    vecs[3] = '{0, 32'h3FC00000, 32'h3FC00000, 32'h40100000, 1'b0, 1'b0};
    vecs[4] = '{1, 32'h00000000, 32'h40400000, 32'h00000000, 1'b0, 1'b0};
    vecs[5] = '{3, 32'hBF800000, 32'h40400000, 32'hC0400000, 1'b0, 1'b0};

    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b0;
    rst = 1'b1;
    tick();
    req_valid = '1;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_y", rsp_y, 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_flags", {30'd0, rsp_uflow, rsp_oflow}, 32'd0);
`ifdef FPMUL_ARB_STATS_EN
    chk("rst_ovf_cnt", 32'(ovf_cnt), 32'd0);
    chk("rst_udf_cnt", 32'(udf_cnt), 32'd0);
`endif
    req_valid = '0;
    tick();
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i]);
`ifdef FPMUL_ARB_STATS_EN
      if (i == 1) chk("ovf_cnt_inc", 32'(ovf_cnt), 32'd1);
      if (i == 2) chk("udf_cnt_inc", 32'(udf_cnt), 32'd1);
`endif
    end

    // fairness: all valid, rsp_ready high, 3-cycle cadence
    ry[0] = 32'h40400000;
    ry[1] = 32'h40800000;
    ry[2] = 32'h3E800000;
    ry[3] = 32'hC0400000;
    do_reset();
    set_req(0, 32'h3FC00000, 32'h40000000);
    set_req(1, 32'h40000000, 32'h40000000);
    set_req(2, 32'h3F000000, 32'h3F000000);
    set_req(3, 32'hC0000000, 32'h3FC00000);
    rsp_ready = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("rr_grant", 32'(req_ready), 32'(1) << (k % 4));
      tick();
      tick();
      chk("rr_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("rr_rsp_id", 32'(rsp_id), 32'(k % 4));
      chk("rr_rsp_y", rsp_y, ry[k % 4]);
      tick();
    end

    // back-pressure: response held, no grants while HOLD
    rsp_ready = 1'b0;
    do_reset();
    req_valid = 4'b0011;
    #1;
    chk("bp_grant0", 32'(req_ready), 32'h1);
    tick();
    tick();
    y_hold = rsp_y;
    chk("bp_y", y_hold, 32'h40400000);
    for (int c = 0; c < 10; c++) begin
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_y_stable", rsp_y, y_hold);
      chk("bp_id_stable", 32'(rsp_id), 32'd0);
      chk("bp_no_grant", 32'(req_ready), 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp_next_grant", 32'(req_ready), 32'h2);
    chk("bp_released", 32'(rsp_valid), 32'd0);

    // reset while in CALC discards the transaction
    req_valid = '0;
    tick();
    tick();
    tick();
    do_reset();
    req_valid = 4'b0100;
    #1;
    chk("rc_grant2", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("rc_no_rsp", 32'(rsp_valid), 32'd0);
      tick();
    end
    req_valid = '1;
    #1;
    chk("rc_first_grant0", 32'(req_ready), 32'h1);
    req_valid = '0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
